// File: rtl/loop_ctrl_pkg.sv
// Shared definitions for the step-down loop gate-drive sequencer:
// FSM state encoding, default dead time and the max1() threshold helper.
package loop_ctrl_pkg;

    // DCM_IDLE is only reachable when the design is built with LOOP_ZCD_EN.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DT_LH    = 3'd1,
        HS_ON    = 3'd2,
        DT_HL    = 3'd3,
        LS_ON    = 3'd4,
        DCM_IDLE = 3'd5
    } loop_state_e;

    // Power-on dead time, in cycles, used when nothing better is known.
    localparam logic [5:0] DT_DEFAULT = 6'd3;

    // A zero-cycle dead time or minimum time still costs one cycle.
    function automatic logic [15:0] max1(input logic [15:0] x);
        return (x == 16'd0) ? 16'd1 : x;
    endfunction

endpackage

// File: rtl/loop_phase_cnt.sv
// Saturating phase counter: loads 1 on state entry, counts up while the
// state is held, sticks at all-ones, and reports cnt >= thresh.
module loop_phase_cnt #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] thresh,
    output logic          ge
);

    logic [TW-1:0] cnt_reg;

    // Load on entry, otherwise count until saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= TW'(1);
        end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign ge = (cnt_reg >= thresh);

endmodule

// File: rtl/loop_gate_seq.sv
// Gate-drive sequencer: turns the loop PWM request into non-overlapping
// high-side / low-side enables with dead times, minimum on/off times,
// a sticky fault shutdown and a wrapping HS pulse counter.
// Build option: define LOOP_ZCD_EN to enable diode emulation (DCM_IDLE
// entered from LS_ON on zero-cross); otherwise zcd is ignored (forced CCM).
module loop_gate_seq
    import loop_ctrl_pkg::*;
#(
    parameter int DT_W  = 6,
    parameter int TW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             CELCLK,
    input  logic             CELRSTN,
    input  logic             en,
    input  logic             pwm,
    input  logic             fault,
    input  logic             zcd,
    input  logic [DT_W-1:0]  dt_lh,
    input  logic [DT_W-1:0]  dt_hl,
    input  logic [TW-1:0]    min_on,
    input  logic [TW-1:0]    min_off,
    output logic             hs_on,
    output logic             ls_on,
    output logic             fault_lat,
    output logic [CNT_W-1:0] sw_cnt
);

    loop_state_e      state_reg;
    loop_state_e      state_next;
    logic             hs_on_reg;
    logic             ls_on_reg;
    logic             fault_lat_reg;
    logic             fault_lat_next;
    logic [CNT_W-1:0] sw_cnt_reg;
    logic             phase_load;
    logic             phase_ge;
    logic [TW-1:0]    phase_thresh;

`ifndef LOOP_ZCD_EN
    logic zcd_unused;
    assign zcd_unused = zcd;
`endif

    // Threshold for the state currently held; config is read live, so a
    // change mid-phase only moves the remaining comparison.
    always_comb begin
        phase_thresh = '0;
        case (state_reg)
            DT_LH:   phase_thresh = TW'(max1(16'(dt_lh)));
            HS_ON:   phase_thresh = TW'(max1(16'(min_on)));
            DT_HL:   phase_thresh = TW'(max1(16'(dt_hl)));
            LS_ON:   phase_thresh = min_off;
            default: phase_thresh = '0;
        endcase
    end

    assign phase_load = (state_next != state_reg);

    loop_phase_cnt #(
        .TW (TW)
    ) u_phase_cnt (
        .clk    (CELCLK),
        .rst_n  (CELRSTN),
        .load   (phase_load),
        .thresh (phase_thresh),
        .ge     (phase_ge)
    );

    // Next-state logic; a fault overrides every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // Never start on the low side: protects a pre-biased output.
                if (en && pwm && !fault_lat_reg) state_next = DT_LH;
            end
            DT_LH: begin
                if (!en)           state_next = IDLE;
                else if (phase_ge) state_next = HS_ON;
            end
            HS_ON: begin
                // Losing en skips min_on but still honours the HS->LS dead time.
                if (!en || (!pwm && phase_ge)) state_next = DT_HL;
            end
            DT_HL: begin
                if (phase_ge) state_next = en ? LS_ON : IDLE;
            end
            LS_ON: begin
                if (!en)                  state_next = IDLE;
                else if (pwm && phase_ge) state_next = DT_LH;
`ifdef LOOP_ZCD_EN
                else if (zcd && phase_ge) state_next = DCM_IDLE;
`endif
            end
`ifdef LOOP_ZCD_EN
            DCM_IDLE: begin
                if (!en)                        state_next = IDLE;
                else if (pwm && !fault_lat_reg) state_next = DT_LH;
            end
`endif
            default: state_next = IDLE;
        endcase
        if (fault) state_next = IDLE;
    end

    // Sticky fault: set by fault, cleared only while disabled and quiet.
    always_comb begin
        fault_lat_next = fault_lat_reg;
        if (fault)    fault_lat_next = 1'b1;
        else if (!en) fault_lat_next = 1'b0;
    end

    // State, registered gate decodes and HS pulse counter.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state_reg     <= IDLE;
            hs_on_reg     <= 1'b0;
            ls_on_reg     <= 1'b0;
            fault_lat_reg <= 1'b0;
            sw_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            hs_on_reg     <= (state_next == HS_ON);
            ls_on_reg     <= (state_next == LS_ON);
            fault_lat_reg <= fault_lat_next;
            if (state_reg == HS_ON && state_next == DT_HL) begin
                sw_cnt_reg <= sw_cnt_reg + 1'b1;
            end
        end
    end

    assign hs_on     = hs_on_reg;
    assign ls_on     = ls_on_reg;
    assign fault_lat = fault_lat_reg;
    assign sw_cnt    = sw_cnt_reg;

endmodule
